ode_ram_arbiter: RTL and testbench

//  Arbitrates one dual-read/single-write coefficient RAM between two requesters:

---
 rtl/ode_ram_arbiter.sv | 154 +++++++++++++++
 tb/tb_ode_ram_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ode_ram_arbiter.sv
// Two-requester (host/engine) ownership arbiter for a dual-read, single-write coefficient RAM.
// Optional ARB_ROUND_ROBIN_EN: tie-break toward the requester not served most recently.
module ode_ram_arbiter #(
    parameter int RAM_ADDRESS_WIDTH = 13,
    parameter int DATA_WIDTH        = 64
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         H_Req,
    input  logic                         E_Req,
    output logic                         H_Grant,
    output logic                         E_Grant,
    input  logic                         H_WR_Enable,
    input  logic                         E_WR_Enable,
    input  logic [RAM_ADDRESS_WIDTH-1:0] H_WR_Address,
    input  logic [RAM_ADDRESS_WIDTH-1:0] E_WR_Address,
    input  logic [DATA_WIDTH-1:0]        H_WR_Data,
    input  logic [DATA_WIDTH-1:0]        E_WR_Data,
    input  logic                         H_RD_Enable,
    input  logic                         E_RD_Enable,
    input  logic [RAM_ADDRESS_WIDTH-1:0] H_RD1_Address,
    input  logic [RAM_ADDRESS_WIDTH-1:0] E_RD1_Address,
    input  logic [RAM_ADDRESS_WIDTH-1:0] H_RD2_Address,
    input  logic [RAM_ADDRESS_WIDTH-1:0] E_RD2_Address,
    output logic                         H_RD_Valid,
    output logic                         E_RD_Valid,
    output logic [DATA_WIDTH-1:0]        RD1_Data,
    output logic [DATA_WIDTH-1:0]        RD2_Data,
    output logic                         RAM_WR_Enable,
    output logic [RAM_ADDRESS_WIDTH-1:0] RAM_WR_Address,
    output logic [DATA_WIDTH-1:0]        RAM_WR_Data,
    output logic [RAM_ADDRESS_WIDTH-1:0] RAM_RD1_Address,
    output logic [RAM_ADDRESS_WIDTH-1:0] RAM_RD2_Address,
    input  logic [DATA_WIDTH-1:0]        RAM_RD1_Data,
    input  logic [DATA_WIDTH-1:0]        RAM_RD2_Data,
    output logic [1:0]                   Owner,
    output logic                         Error
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_HOST = 2'b01,
        ST_ENG  = 2'b10
    } state_e;

    state_e state_q, state_d;
    state_e tie_winner;

    logic                  h_vld_q, h_vld_d;
    logic                  e_vld_q, e_vld_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] rd1_q, rd2_q;

`ifdef ARB_ROUND_ROBIN_EN
    // Last requester to receive a fresh grant; engine at reset so host wins the first tie.
    state_e last_q, last_d;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) last_q <= ST_ENG;
        else     last_q <= last_d;
    end

    always_comb begin
        last_d = last_q;
        if (state_d != ST_IDLE && state_d != state_q)
            last_d = state_d;
    end

    assign tie_winner = (last_q == ST_HOST) ? ST_ENG : ST_HOST;
`else
    assign tie_winner = ST_HOST;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Owner keeps the RAM while its request is held; on release hand straight to a waiter.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (H_Req && E_Req) state_d = tie_winner;
                else if (H_Req)     state_d = ST_HOST;
                else if (E_Req)     state_d = ST_ENG;
            end
            ST_HOST: if (!H_Req) state_d = E_Req ? ST_ENG : ST_IDLE;
            ST_ENG:  if (!E_Req) state_d = H_Req ? ST_HOST : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign Owner   = state_q;
    assign H_Grant = (state_q == ST_HOST);
    assign E_Grant = (state_q == ST_ENG);

    always_comb begin
        RAM_WR_Enable   = 1'b0;
        RAM_WR_Address  = '0;
        RAM_WR_Data     = '0;
        RAM_RD1_Address = '0;
        RAM_RD2_Address = '0;
        case (state_q)
            ST_HOST: begin
                RAM_WR_Enable   = H_WR_Enable;
                RAM_WR_Address  = H_WR_Address;
                RAM_WR_Data     = H_WR_Data;
                RAM_RD1_Address = H_RD1_Address;
                RAM_RD2_Address = H_RD2_Address;
            end
            ST_ENG: begin
                RAM_WR_Enable   = E_WR_Enable;
                RAM_WR_Address  = E_WR_Address;
                RAM_WR_Data     = E_WR_Data;
                RAM_RD1_Address = E_RD1_Address;
                RAM_RD2_Address = E_RD2_Address;
            end
            default: ;
        endcase
    end

    // Valid follows the issuer, not the current owner, so a read on the last granted cycle still lands.
    always_comb begin
        h_vld_d = H_RD_Enable && (state_q == ST_HOST);
        e_vld_d = E_RD_Enable && (state_q == ST_ENG);
        err_d   = err_q
                | ((H_WR_Enable || H_RD_Enable) && (state_q != ST_HOST))
                | ((E_WR_Enable || E_RD_Enable) && (state_q != ST_ENG));
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            h_vld_q <= 1'b0;
            e_vld_q <= 1'b0;
            err_q   <= 1'b0;
            rd1_q   <= '0;
            rd2_q   <= '0;
        end else begin
            h_vld_q <= h_vld_d;
            e_vld_q <= e_vld_d;
            err_q   <= err_d;
            rd1_q   <= RAM_RD1_Data;
            rd2_q   <= RAM_RD2_Data;
        end
    end

    assign H_RD_Valid = h_vld_q;
    assign E_RD_Valid = e_vld_q;
    assign Error      = err_q;
    assign RD1_Data   = rd1_q;
    assign RD2_Data   = rd2_q;

endmodule

// File: tb/tb_ode_ram_arbiter.sv
// Directed bench for ode_ram_arbiter: RAM behavioural model, per-cycle reference model and literal spot checks.
module tb_ode_ram_arbiter;
    localparam int AW = 13;
    localparam int DW = 64;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    localparam logic [1:0] IDLE = 2'b00, HOST = 2'b01, ENG = 2'b10;

    logic CLK, RST;
    logic H_Req, E_Req, H_Grant, E_Grant;
    logic H_WR_Enable, E_WR_Enable, H_RD_Enable, E_RD_Enable;
    logic [AW-1:0] H_WR_Address, E_WR_Address, H_RD1_Address, E_RD1_Address, H_RD2_Address, E_RD2_Address;
    logic [DW-1:0] H_WR_Data, E_WR_Data;
    logic H_RD_Valid, E_RD_Valid;
    logic [DW-1:0] RD1_Data, RD2_Data;
    logic RAM_WR_Enable;
    logic [AW-1:0] RAM_WR_Address, RAM_RD1_Address, RAM_RD2_Address;
    logic [DW-1:0] RAM_WR_Data, RAM_RD1_Data, RAM_RD2_Data;
    logic [1:0] Owner;
    logic Error;

    int tests = 0;
    int fails = 0;

    ode_ram_arbiter #(.RAM_ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .CLK(CLK), .RST(RST),
        .H_Req(H_Req), .E_Req(E_Req), .H_Grant(H_Grant), .E_Grant(E_Grant),
        .H_WR_Enable(H_WR_Enable), .E_WR_Enable(E_WR_Enable),
        .H_WR_Address(H_WR_Address), .E_WR_Address(E_WR_Address),
        .H_WR_Data(H_WR_Data), .E_WR_Data(E_WR_Data),
        .H_RD_Enable(H_RD_Enable), .E_RD_Enable(E_RD_Enable),
        .H_RD1_Address(H_RD1_Address), .E_RD1_Address(E_RD1_Address),
        .H_RD2_Address(H_RD2_Address), .E_RD2_Address(E_RD2_Address),
        .H_RD_Valid(H_RD_Valid), .E_RD_Valid(E_RD_Valid),
        .RD1_Data(RD1_Data), .RD2_Data(RD2_Data),
        .RAM_WR_Enable(RAM_WR_Enable), .RAM_WR_Address(RAM_WR_Address), .RAM_WR_Data(RAM_WR_Data),
        .RAM_RD1_Address(RAM_RD1_Address), .RAM_RD2_Address(RAM_RD2_Address),
        .RAM_RD1_Data(RAM_RD1_Data), .RAM_RD2_Data(RAM_RD2_Data),
        .Owner(Owner), .Error(Error)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // RAM device: combinational read, synchronous write.
    bit [DW-1:0] ram [0:(1<<AW)-1];
    always @(posedge CLK) if (RAM_WR_Enable) ram[RAM_WR_Address] <= RAM_WR_Data;
    assign RAM_RD1_Data = ram[RAM_RD1_Address];
    assign RAM_RD2_Data = ram[RAM_RD2_Address];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: who owns the RAM after an edge.
    function automatic logic [1:0] arb(input logic [1:0] cur, input logic h, input logic e, input logic [1:0] last);
        if (cur == HOST && h) return HOST;
        if (cur == ENG && e)  return ENG;
        if (h && e)           return (RR && last == HOST) ? ENG : HOST;
        if (h)                return HOST;
        if (e)                return ENG;
        return IDLE;
    endfunction

    logic [1:0] m_own, m_last, m_nxt;
    logic m_hv, m_ev, m_err;
    logic [DW-1:0] m_rd1, m_rd2;
    bit [DW-1:0] exp_mem [0:(1<<AW)-1];

    wire          x_h  = (m_own == HOST);
    wire          x_e  = (m_own == ENG);
    wire          x_we = x_h ? H_WR_Enable : x_e ? E_WR_Enable : 1'b0;
    wire [AW-1:0] x_wa = x_h ? H_WR_Address : x_e ? E_WR_Address : '0;
    wire [DW-1:0] x_wd = x_h ? H_WR_Data : x_e ? E_WR_Data : '0;
    wire [AW-1:0] x_r1 = x_h ? H_RD1_Address : x_e ? E_RD1_Address : '0;
    wire [AW-1:0] x_r2 = x_h ? H_RD2_Address : x_e ? E_RD2_Address : '0;
    assign m_nxt = arb(m_own, H_Req, E_Req, m_last);

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_own <= IDLE; m_last <= ENG; m_hv <= 1'b0; m_ev <= 1'b0;
            m_err <= 1'b0; m_rd1 <= '0; m_rd2 <= '0;
        end else begin
            m_own <= m_nxt;
            if (m_nxt != IDLE && m_nxt != m_own) m_last <= m_nxt;
            m_hv  <= x_h && H_RD_Enable;
            m_ev  <= x_e && E_RD_Enable;
            m_err <= m_err || (!x_h && (H_WR_Enable || H_RD_Enable)) || (!x_e && (E_WR_Enable || E_RD_Enable));
            m_rd1 <= exp_mem[x_r1];
            m_rd2 <= exp_mem[x_r2];
        end
    end
    always @(posedge CLK) if (!RST && x_we) exp_mem[x_wa] <= x_wd;

    always @(negedge CLK) begin
        check("owner", {62'd0, Owner}, {62'd0, m_own});
        check("h_grant", {63'd0, H_Grant}, {63'd0, x_h});
        check("e_grant", {63'd0, E_Grant}, {63'd0, x_e});
        check("ram_we", {63'd0, RAM_WR_Enable}, {63'd0, x_we});
        check("ram_wa", {51'd0, RAM_WR_Address}, {51'd0, x_wa});
        check("ram_wd", RAM_WR_Data, x_wd);
        check("ram_r1", {51'd0, RAM_RD1_Address}, {51'd0, x_r1});
        check("ram_r2", {51'd0, RAM_RD2_Address}, {51'd0, x_r2});
        check("h_valid", {63'd0, H_RD_Valid}, {63'd0, m_hv});
        check("e_valid", {63'd0, E_RD_Valid}, {63'd0, m_ev});
        check("rd1", RD1_Data, m_rd1);
        check("rd2", RD2_Data, m_rd2);
        check("error", {63'd0, Error}, {63'd0, m_err});
    end

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL timeout: run did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        RST = 1'b1;
        H_Req = 0; E_Req = 0; H_WR_Enable = 0; E_WR_Enable = 0; H_RD_Enable = 0; E_RD_Enable = 0;
        H_WR_Address = '0; E_WR_Address = '0; H_WR_Data = '0; E_WR_Data = '0;
        H_RD1_Address = '0; E_RD1_Address = '0; H_RD2_Address = '0; E_RD2_Address = '0;
        #2;
        check("rst_owner", {62'd0, Owner}, 64'd0);
        check("rst_grants", {62'd0, H_Grant, E_Grant}, 64'd0);
        check("rst_error", {63'd0, Error}, 64'd0);
        check("rst_rd1", RD1_Data, 64'd0);
        @(negedge CLK); #1;
        RST = 1'b0;

        // T1: reset in the middle of a host write
        H_Req = 1; tick();
        check("t1_h_grant", {63'd0, H_Grant}, 64'd1);
        H_WR_Enable = 1; H_WR_Address = 13'd3; H_WR_Data = 64'h33;
        #2 RST = 1'b1;
        #1;
        check("t1_grant_drop", {63'd0, H_Grant}, 64'd0);
        check("t1_we_drop", {63'd0, RAM_WR_Enable}, 64'd0);
        check("t1_owner", {62'd0, Owner}, 64'd0);
        check("t1_error", {63'd0, Error}, 64'd0);
        @(negedge CLK); #1;
        RST = 1'b0; H_Req = 0; H_WR_Enable = 0;
        check("t1_ram3", ram[3], 64'd0);

        // T2: engine alone; write then read-before-write then read
        E_Req = 1; tick();
        check("t2_e_grant", {62'd0, H_Grant, E_Grant}, 64'd1);
        E_WR_Enable = 1; E_WR_Address = 13'd5; E_WR_Data = 64'hA5; tick();
        E_WR_Data = 64'hBB; E_RD_Enable = 1; E_RD1_Address = 13'd5; E_RD2_Address = 13'd3; tick();
        check("t2_e_valid", {63'd0, E_RD_Valid}, 64'd1);
        check("t2_rd1_old", RD1_Data, 64'hA5);
        check("t2_rd2", RD2_Data, 64'd0);
        E_WR_Enable = 0; tick();
        check("t2_rd1_new", RD1_Data, 64'hBB);
        E_RD_Enable = 0;

        // T3: ties
        E_Req = 0; tick(); tick();
        check("t3_idle", {62'd0, Owner}, 64'd0);
        H_Req = 1; E_Req = 1; tick();
        check("t3_tie1", {62'd0, E_Grant, H_Grant}, 64'd1);
        H_Req = 0; E_Req = 0; tick();
        H_Req = 1; E_Req = 1; tick();
        check("t3_tie2", {62'd0, E_Grant, H_Grant}, RR ? 64'd2 : 64'd1);
        H_Req = 0; E_Req = 0; tick();

        // T4: direct handover host -> engine
        H_Req = 1; tick();
        E_Req = 1; tick();
        check("t4_hold", {62'd0, Owner}, 64'd1);
        H_Req = 0; tick();
        check("t4_handover", {62'd0, Owner}, 64'd2);
        check("t4_h_drop", {63'd0, H_Grant}, 64'd0);
        E_Req = 0; H_Req = 1; tick();
        check("t4_back", {62'd0, Owner}, 64'd1);

        // T5: engine writes while host owns
        H_WR_Enable = 1; H_WR_Address = 13'd7; H_WR_Data = 64'h77; tick();
        H_WR_Enable = 0; E_WR_Enable = 1; E_WR_Address = 13'd7; E_WR_Data = 64'hEE; tick();
        check("t5_error", {63'd0, Error}, 64'd1);
        E_WR_Enable = 0; tick();
        check("t5_error_held", {63'd0, Error}, 64'd1);
        check("t5_ram7", ram[7], 64'h77);

        // T6: host reads on its last granted cycle while engine waits
        E_Req = 1; H_Req = 0; H_RD_Enable = 1; H_RD1_Address = 13'd7; H_RD2_Address = 13'd5; tick();
        check("t6_h_valid", {63'd0, H_RD_Valid}, 64'd1);
        check("t6_e_valid", {63'd0, E_RD_Valid}, 64'd0);
        check("t6_e_grant", {63'd0, E_Grant}, 64'd1);
        check("t6_rd1", RD1_Data, 64'h77);
        check("t6_rd2", RD2_Data, 64'hBB);
        H_RD_Enable = 0; tick();
        check("t6_h_valid_off", {63'd0, H_RD_Valid}, 64'd0);

        E_Req = 0; tick();
        #2 RST = 1'b1;
        #1 check("end_error_clear", {63'd0, Error}, 64'd0);
        @(negedge CLK); #1;
        RST = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
